// File: rtl/regfile_mp.sv
// Multi-port CPU register file: two combinational read ports, two write ports,
// optional write-through bypass and zero register, post-reset clear sweep and RAW scoreboard.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic              busy0,
  output logic              busy1,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              rf_ready
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0]    mem [NUM_REGS];

  logic in_ready;
  logic wv0, wv1, cv;

  // Qualified write/claim strobes: nothing lands before the sweep ends, r0 drops them when hardwired
  assign in_ready = (state_q == READY);
  assign wv0 = in_ready && we0      && !(ZERO_REG != 0 && wa0 == '0);
  assign wv1 = in_ready && we1      && !(ZERO_REG != 0 && wa1 == '0);
  assign cv  = in_ready && claim_en && !(ZERO_REG != 0 && claim_addr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Sweep sequencing and scoreboard update; a claim overrides a same-cycle write release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
          ready_d = 1'b1;
        end
      end
      READY: begin
        if (wv0) busy_d[wa0] = 1'b0;
        if (wv1) busy_d[wa1] = 1'b0;
        if (cv)  busy_d[claim_addr] = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Storage is not reset; the sweep zeroes it. Port 1 is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wv0) mem[wa0] <= wd0;
      if (wv1) mem[wa1] <= wd1;
    end
  end

  logic [1:0][ADDR_W-1:0] ra;
  logic [1:0][DATA_W-1:0] rd_v;
  logic [1:0]             busy_v;

  assign ra = {ra1, ra0};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit0, hit1, chit, zero, fwd;
    assign hit0 = wv0 && (wa0 == ra[p]);
    assign hit1 = wv1 && (wa1 == ra[p]);
    assign chit = cv && (claim_addr == ra[p]);
    assign zero = (ZERO_REG != 0) && (ra[p] == '0);
    assign fwd  = (BYPASS != 0);

    assign rd_v[p] = (!in_ready || zero) ? '0 :
                     (fwd && hit1)       ? wd1 :
                     (fwd && hit0)       ? wd0 :
                                           mem[ra[p]];

    assign busy_v[p] = (!in_ready || zero)             ? 1'b0 :
                       (fwd && (hit0 || hit1) && !chit) ? 1'b0 :
                                                          busy_q[ra[p]];
  end

  assign rd0      = rd_v[0];
  assign rd1      = rd_v[1];
  assign busy0    = busy_v[0];
  assign busy1    = busy_v[1];
  assign rf_ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypass build and a non-bypass build share stimulus
// and are compared every cycle against an array-level reference model.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ra0, ra1, wa0, wa1, claim_addr;
  logic [DW-1:0] wd0, wd1;
  logic          we0, we1, claim_en;

  logic [DW-1:0] rd0, rd1, n_rd0, n_rd1;
  logic          busy0, busy1, n_busy0, n_busy1, rf_ready, n_rf_ready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .busy0(busy0), .busy1(busy1), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .claim_en(claim_en),
    .claim_addr(claim_addr), .rf_ready(rf_ready)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .ra0(ra0), .ra1(ra1), .rd0(n_rd0), .rd1(n_rd1),
    .busy0(n_busy0), .busy1(n_busy1), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .claim_en(claim_en),
    .claim_addr(claim_addr), .rf_ready(n_rf_ready)
  );

  typedef struct {
    logic          rst;
    logic [AW-1:0] ra0, ra1;
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          claim_en;
    logic [AW-1:0] claim_addr;
  } stim_t;

  typedef struct {
    logic          ready;
    logic [DW-1:0] rd0, rd1, nrd0, nrd1;
    logic          busy0, busy1, nbusy0, nbusy1;
  } exp_t;

  exp_t q[$];

  // Reference model: register contents, pending bits and cycles elapsed since reset release
  logic [DW-1:0] m_mem [NR];
  bit            m_busy [NR];
  int            m_cyc = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra, input stim_t s, input bit byp);
    if (m_cyc < NR || ra == 0) return '0;
    if (byp && s.we1 && s.wa1 == ra) return s.wd1;
    if (byp && s.we0 && s.wa0 == ra) return s.wd0;
    return m_mem[ra];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra, input stim_t s, input bit byp);
    bit wr_hit, cl_hit;
    if (m_cyc < NR || ra == 0) return 1'b0;
    wr_hit = (s.we0 && s.wa0 == ra) || (s.we1 && s.wa1 == ra);
    cl_hit = s.claim_en && s.claim_addr == ra;
    if (byp && wr_hit && !cl_hit) return 1'b0;
    return m_busy[ra];
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    e.ready  = (m_cyc >= NR);
    e.rd0    = exp_rd(s.ra0, s, 1'b1);
    e.rd1    = exp_rd(s.ra1, s, 1'b1);
    e.nrd0   = exp_rd(s.ra0, s, 1'b0);
    e.nrd1   = exp_rd(s.ra1, s, 1'b0);
    e.busy0  = exp_busy(s.ra0, s, 1'b1);
    e.busy1  = exp_busy(s.ra1, s, 1'b1);
    e.nbusy0 = exp_busy(s.ra0, s, 1'b0);
    e.nbusy1 = exp_busy(s.ra1, s, 1'b0);
    return e;
  endfunction

  // Drive one cycle of stimulus, queue its expected response, then advance the model past the edge
  task automatic apply(input stim_t s);
    rst = s.rst; ra0 = s.ra0; ra1 = s.ra1;
    we0 = s.we0; wa0 = s.wa0; wd0 = s.wd0;
    we1 = s.we1; wa1 = s.wa1; wd1 = s.wd1;
    claim_en = s.claim_en; claim_addr = s.claim_addr;
    if (s.rst) begin
      m_cyc = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end
    q.push_back(predict(s));
    @(posedge clk);
    #1;
    if (!s.rst) begin
      if (m_cyc < NR) begin
        m_cyc++;
        if (m_cyc == NR) foreach (m_mem[i]) m_mem[i] = '0;
      end else begin
        if (s.we0 && s.wa0 != 0) m_mem[s.wa0] = s.wd0;
        if (s.we1 && s.wa1 != 0) m_mem[s.wa1] = s.wd1;
        if (s.we0) m_busy[s.wa0] = 1'b0;
        if (s.we1) m_busy[s.wa1] = 1'b0;
        if (s.claim_en && s.claim_addr != 0) m_busy[s.claim_addr] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: whenever a response is outstanding, sample mid-cycle and compare
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rf_ready",   DW'(rf_ready),   DW'(e.ready));
        chk("nb_rf_ready", DW'(n_rf_ready), DW'(e.ready));
        chk("rd0",    rd0,   e.rd0);
        chk("rd1",    rd1,   e.rd1);
        chk("busy0",  DW'(busy0),   DW'(e.busy0));
        chk("busy1",  DW'(busy1),   DW'(e.busy1));
        chk("nb_rd0", n_rd0, e.nrd0);
        chk("nb_rd1", n_rd1, e.nrd1);
        chk("nb_busy0", DW'(n_busy0), DW'(e.nbusy0));
        chk("nb_busy1", DW'(n_busy1), DW'(e.nbusy1));
      end
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, NR - 1));
  endfunction

  initial begin
    stim_t s;
    ra0 = '0; ra1 = '0; we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0; claim_en = 1'b0; claim_addr = '0;
    @(posedge clk);
    #1;

    // Reset, then full sweep with writes/claims that must be ignored
    s = idle(); s.rst = 1'b1;
    apply(s); apply(s);
    for (int i = 0; i < int'(NR); i++) begin
      s = idle(); s.ra0 = AW'(i); s.ra1 = 5'd5;
      s.we0 = 1'b1; s.wa0 = 5'd5; s.wd0 = 32'h5555_5555;
      s.claim_en = 1'b1; s.claim_addr = AW'(i);
      apply(s);
    end
    for (int i = 0; i < int'(NR); i++) begin
      s = idle(); s.ra0 = AW'(i); s.ra1 = AW'(NR - 1 - i);
      apply(s);
    end

    // Reset during the sweep restarts the full count
    s = idle(); s.rst = 1'b1;
    apply(s); apply(s);
    s = idle();
    repeat (10) apply(s);
    s.rst = 1'b1; apply(s);
    for (int i = 0; i < int'(NR) + 2; i++) begin
      s = idle(); s.ra0 = 5'd5;
      s.we0 = 1'b1; s.wa0 = 5'd5; s.wd0 = 32'h0BAD_0005;
      if (i >= int'(NR)) s.we0 = 1'b0;
      apply(s);
    end

    // Dual-write collision on r7
    s = idle(); s.ra0 = 5'd7; s.ra1 = 5'd7;
    s.we0 = 1'b1; s.wa0 = 5'd7; s.wd0 = 32'h1111_1111;
    s.we1 = 1'b1; s.wa1 = 5'd7; s.wd1 = 32'h2222_2222;
    apply(s);
    s = idle(); s.ra0 = 5'd7; apply(s);

    // Hardwired zero register
    s = idle(); s.ra0 = 5'd0;
    s.we0 = 1'b1; s.wa0 = 5'd0; s.wd0 = 32'hDEAD_BEEF;
    s.claim_en = 1'b1; s.claim_addr = 5'd0;
    apply(s);
    s = idle(); s.ra0 = 5'd0; apply(s);

    // Scoreboard claim, release by write, and claim-wins collision on r9
    s = idle(); s.ra0 = 5'd9; s.claim_en = 1'b1; s.claim_addr = 5'd9; apply(s);
    s = idle(); s.ra0 = 5'd9; apply(s);
    s = idle(); s.ra0 = 5'd9; s.we1 = 1'b1; s.wa1 = 5'd9; s.wd1 = 32'hCAFE_0001; apply(s);
    s = idle(); s.ra0 = 5'd9; apply(s);
    s = idle(); s.ra0 = 5'd9; s.ra1 = 5'd9;
    s.claim_en = 1'b1; s.claim_addr = 5'd9;
    s.we0 = 1'b1; s.wa0 = 5'd9; s.wd0 = 32'h0000_0999;
    apply(s);
    s = idle(); s.ra0 = 5'd9; apply(s);

    // Write visibility: same cycle on the bypass build, next cycle on the other
    s = idle(); s.ra0 = 5'd3; s.we0 = 1'b1; s.wa0 = 5'd3; s.wd0 = 32'h0000_ABCD; apply(s);
    s = idle(); s.ra0 = 5'd3; apply(s);

    // Randomized traffic with occasional resets
    repeat (3000) begin
      s.rst        = ($urandom_range(0, 799) == 0);
      s.ra0        = rand_addr();
      s.ra1        = rand_addr();
      s.we0        = 1'($urandom_range(0, 1));
      s.wa0        = rand_addr();
      s.wd0        = $urandom();
      s.we1        = ($urandom_range(0, 2) == 0);
      s.wa1        = rand_addr();
      s.wd1        = $urandom();
      s.claim_en   = ($urandom_range(0, 2) == 0);
      s.claim_addr = rand_addr();
      apply(s);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", DW'(q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the single-port CPU register file. It provides two combinational read ports and two write ports, with optional write-through bypass and an optional hardwired zero register. A post-reset clear sequencer sweeps the array to zero and raises rf_ready. A per-register pending-write scoreboard lets the pipelined datapath detect RAW hazards. It sits between decode (reads, claims) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/claims
BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read data

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
ra0  in  ADDR_W  read address port 0 (rs)
ra1  in  ADDR_W  read address port 1 (rt)
rd0  out  DATA_W  read data port 0
rd1  out  DATA_W  read data port 1
busy0  out  1  pending write outstanding on ra0
busy1  out  1  pending write outstanding on ra1
we0  in  1  write enable port 0 (ALU writeback)
wa0  in  ADDR_W  write address port 0
wd0  in  DATA_W  write data port 0
we1  in  1  write enable port 1 (load/long-latency writeback)
wa1  in  ADDR_W  write address port 1
wd1  in  DATA_W  write data port 1
claim_en  in  1  mark claim_addr as pending-write
claim_addr  in  ADDR_W  destination being claimed at issue
rf_ready  out  1  clear sweep done, file usable

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. The array itself is not reset; the clear sequencer zeroes it.
- FSM states: CLEAR, READY.
- rst asserted (any time, including mid-sweep or mid-operation): state=CLEAR, sweep counter=0, rf_ready=0, all busy bits=0.
- CLEAR: each cycle writes 0 to array[counter], then counter++. After writing NUM_REGS-1, next state is READY. The sweep takes exactly NUM_REGS cycles after rst deasserts, then rf_ready=1 (registered).
- While in CLEAR:
  - we0/we1/claim_en are ignored.
  - rd0/rd1 read 0 and busy0/busy1 read 0.
- READY writes:
  - Array updates on the rising edge.
  - we0 and we1 to the same address: port 1 wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Reads are combinational: rdN = array[raN].
  - With ZERO_REG=1 and raN==0: rdN=0, regardless of bypass.
  - With BYPASS=1, a same-cycle valid write to raN forwards its data. Priority is wd1, then wd0, then the array.
  - With BYPASS=0, the new value is visible the cycle after the write.
- Scoreboard, one bit per register:
  - claim_en sets busy[claim_addr].
  - A write on either port clears busy[wa].
  - Claim and write to the same address in the same cycle: busy ends set (new claim wins).
  - With ZERO_REG=1, register 0 is never busy.
- busyN = busy[raN] (combinational).
  - With BYPASS=1, busyN is forced to 0 when a same-cycle write to raN is present and no same-cycle claim targets raN.
- Claiming an already-busy register is legal; the bit stays set. There is no counting.
- rf_ready stays 1 until the next rst.

Test Plan:
- Sweep: rst 2 cycles, release -> rf_ready=0 for exactly 32 cycles then 1. Reads of all 32 addresses return 0x00000000.
- Reset mid-sweep: assert rst at sweep cycle 10, release -> rf_ready rises 32 cycles after the second release. We0 to r5 issued during CLEAR has no effect (r5 reads 0).
- Dual write collision: we0(wa0=7, wd0=0x11111111) and we1(wa1=7, wd1=0x22222222) in the same cycle -> r7 reads 0x22222222 next cycle. With BYPASS=1, rd0 (ra0=7) shows 0x22222222 in the same cycle.
- Zero register: we0 to r0 with 0xDEADBEEF and claim r0 -> rd0=0 and busy0=0 at all times.
- Scoreboard: claim r9 -> busy0 (ra0=9) is 1 next cycle. Later we1 to r9 with 0xCAFE0001 -> busy0=0 and rd0=0xCAFE0001 in the same cycle (BYPASS=1). Claim and we0 on r9 in the same cycle -> busy stays 1.
- BYPASS=0 build: write r3=0x0000ABCD -> rd0 (ra0=3) shows the old value that cycle and 0x0000ABCD the next cycle.
